// File: rtl/m72_pkg.sv
// Shared types and constants for the nested M72 interrupt controller.
package m72_pkg;

    typedef enum logic [2:0] {
        UNINIT,
        INIT_IW2,
        INIT_IW3,
        INIT_IW4,
        INIT_DONE
    } init_state_e;

    localparam logic [1:0] ADDR_CMD    = 2'd0;
    localparam logic [1:0] ADDR_IMR_LO = 2'd1;
    localparam logic [1:0] ADDR_IMR_HI = 2'd2;
    localparam logic [1:0] ADDR_EOI    = 2'd3;

    typedef enum logic [1:0] {
        RB_IRR,
        RB_ISR,
        RB_IMR,
        RB_TOP
    } rb_sel_e;

endpackage

// File: rtl/m72_pic_prio.sv
// Rotating priority encoder: first set bit of req scanning circularly upward from base.
module m72_pic_prio #(
    parameter int unsigned N_IRQ = 8
) (
    input  logic [N_IRQ-1:0]         req,
    input  logic [$clog2(N_IRQ)-1:0] base,
    output logic                     valid,
    output logic [$clog2(N_IRQ)-1:0] level
);
    localparam int unsigned LVL_W = $clog2(N_IRQ);

    logic [LVL_W-1:0] idx;

    // Scan from lowest priority to highest so the last hit is the winner.
    always_comb begin
        valid = 1'b0;
        level = '0;
        idx   = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            idx = base + LVL_W'(i);
            if (req[idx]) begin
                valid = 1'b1;
                level = idx;
            end
        end
    end

endmodule

// File: rtl/m72_pic_nested.sv
// Fully nested M72 interrupt controller: init-word programming, IRR/ISR/IMR, EOI, rotation, readback.
module m72_pic_nested
    import m72_pkg::*;
#(
    parameter int unsigned N_IRQ = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic             cs,
    input  logic             wr,
    input  logic             rd,
    input  logic [1:0]       addr,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    input  logic [N_IRQ-1:0] intp,
    output logic             int_req,
    output logic [7:0]       int_vector,
    input  logic             int_ack
);
    localparam int unsigned LVL_W = $clog2(N_IRQ);

    init_state_e      state;
    rb_sel_e          rb_sel;
    logic             ltim, sngl, ic4, aeoi;
    logic [7:LVL_W]   vec_base;
    logic [N_IRQ-1:0] imr, irr, isr, intp_q;
    logic [LVL_W-1:0] base;

    logic             wr_en, rd_en, iw1_wr, done, ack, eoi_wr, eoi_hit, raise_c;
    logic             req_valid, isr_valid;
    logic [LVL_W-1:0] req_lvl, isr_lvl, eoi_lvl, int_level, rank_req, rank_isr;
    logic [N_IRQ-1:0] ack_hot, eoi_hot, irr_next, isr_next, imr_hi_next;
    logic [15:0]      sel_val;

    m72_pic_prio #(.N_IRQ(N_IRQ)) u_prio_req (
        .req   (irr & ~imr),
        .base  (base),
        .valid (req_valid),
        .level (req_lvl)
    );

    m72_pic_prio #(.N_IRQ(N_IRQ)) u_prio_isr (
        .req   (isr),
        .base  (base),
        .valid (isr_valid),
        .level (isr_lvl)
    );

    assign wr_en     = ce & cs & wr;
    assign rd_en     = ce & cs & rd;
    assign iw1_wr    = wr_en && (addr == ADDR_CMD) && din[4];
    assign done      = (state == INIT_DONE);
    assign ack       = int_ack & int_req;
    assign eoi_wr    = wr_en && done && (addr == ADDR_EOI);
    assign int_level = int_vector[LVL_W-1:0];
    assign rank_req  = req_lvl - base;
    assign rank_isr  = isr_lvl - base;
    // Only a strictly higher priority than everything in service may interrupt.
    assign raise_c   = done && req_valid && (!isr_valid || (rank_req < rank_isr));

    // Next-state terms for the request/in-service/mask vectors and readback mux.
    always_comb begin
        ack_hot  = ack ? (N_IRQ'(1) << int_level) : '0;
        irr_next = ltim ? intp : ((irr & ~ack_hot) | (intp & ~intp_q));
        eoi_lvl  = din[7] ? isr_lvl : din[LVL_W-1:0];
        eoi_hit  = eoi_wr && (!din[7] || isr_valid);
        eoi_hot  = eoi_hit ? (N_IRQ'(1) << eoi_lvl) : '0;
        isr_next = (isr & ~eoi_hot) | (aeoi ? '0 : ack_hot);
        imr_hi_next = imr;
        for (int i = 8; i < N_IRQ; i++) begin
            imr_hi_next[i] = din[3'(i - 8)];
        end
        case (rb_sel)
            RB_IRR:  sel_val = 16'(irr);
            RB_ISR:  sel_val = 16'(isr);
            RB_IMR:  sel_val = 16'(imr);
            default: sel_val = isr_valid ? 16'(isr_lvl) : 16'h00FF;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= UNINIT;
            rb_sel     <= RB_IRR;
            ltim       <= 1'b0;
            sngl       <= 1'b0;
            ic4        <= 1'b0;
            aeoi       <= 1'b0;
            vec_base   <= '0;
            imr        <= '0;
            irr        <= '0;
            isr        <= '0;
            intp_q     <= '0;
            base       <= '0;
            int_req    <= 1'b0;
            int_vector <= 8'h00;
            dout       <= 8'h00;
        end else if (ce) begin
            intp_q <= intp;
            if (rd_en) begin
                case (addr)
                    ADDR_CMD:    dout <= sel_val[7:0];
                    ADDR_IMR_HI: dout <= sel_val[15:8];
                    default:     dout <= 8'h00;
                endcase
            end
            if (iw1_wr) begin
                // IW1 restarts programming and overrides any same-cycle ack or EOI.
                state   <= INIT_IW2;
                ltim    <= din[3];
                sngl    <= din[1];
                ic4     <= din[0];
                aeoi    <= 1'b0;
                imr     <= '0;
                irr     <= '0;
                isr     <= '0;
                base    <= '0;
                int_req <= 1'b0;
                rb_sel  <= RB_IRR;
            end else begin
                if (wr_en && (addr == ADDR_CMD)) begin
                    rb_sel <= rb_sel_e'(din[1:0]);
                end
                if (wr_en && (addr == ADDR_IMR_LO)) begin
                    case (state)
                        INIT_IW2: begin
                            vec_base <= din[7:LVL_W];
                            state    <= !sngl ? INIT_IW3 : (ic4 ? INIT_IW4 : INIT_DONE);
                        end
                        INIT_IW3: state <= ic4 ? INIT_IW4 : INIT_DONE;
                        INIT_IW4: begin
                            aeoi  <= din[1];
                            state <= INIT_DONE;
                        end
                        INIT_DONE: imr[7:0] <= din;
                        default: ;
                    endcase
                end
                if (done) begin
                    irr <= irr_next;
                    isr <= isr_next;
                    if (wr_en && (addr == ADDR_IMR_HI)) begin
                        imr <= imr_hi_next;
                    end
                    if (eoi_hit && din[6]) begin
                        base <= eoi_lvl + LVL_W'(1);
                    end
                    if (ack) begin
                        int_req <= 1'b0;
                    end else if (!int_req && raise_c) begin
                        int_req    <= 1'b1;
                        int_vector <= {vec_base, req_lvl};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_m72_pic_nested.sv
// Directed bench for m72_pic_nested: an 8-input and a 16-input instance on a shared bus.
module tb_m72_pic_nested;
    logic        clk = 1'b0;
    logic        reset_n, ce, wr, rd, cs8, cs16, ack8, ack16;
    logic [1:0]  addr;
    logic [7:0]  din, dout8, dout16, vec8, vec16, rdata;
    logic [7:0]  intp8;
    logic [15:0] intp16;
    logic        req8, req16;
    int          n_checks = 0;
    int          n_pass   = 0;

    m72_pic_nested #(.N_IRQ(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .cs(cs8), .wr(wr), .rd(rd),
        .addr(addr), .din(din), .dout(dout8), .intp(intp8),
        .int_req(req8), .int_vector(vec8), .int_ack(ack8)
    );

    m72_pic_nested #(.N_IRQ(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .cs(cs16), .wr(wr), .rd(rd),
        .addr(addr), .din(din), .dout(dout16), .intp(intp16),
        .int_req(req16), .int_vector(vec16), .int_ack(ack16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input bit d16, input logic [1:0] a, input logic [7:0] d);
        cs8 = !d16; cs16 = d16; wr = 1'b1; addr = a; din = d;
        tick();
        cs8 = 1'b0; cs16 = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input bit d16, input logic [1:0] a, output logic [7:0] d);
        cs8 = !d16; cs16 = d16; rd = 1'b1; addr = a;
        tick();
        cs8 = 1'b0; cs16 = 1'b0; rd = 1'b0;
        d = d16 ? dout16 : dout8;
    endtask

    task automatic pulse(input bit d16, input int lvl);
        if (d16) intp16[lvl] = 1'b1; else intp8[lvl] = 1'b1;
        tick();
        if (d16) intp16[lvl] = 1'b0; else intp8[lvl] = 1'b0;
    endtask

    task automatic ack(input bit d16);
        if (d16) ack16 = 1'b1; else ack8 = 1'b1;
        tick();
        ack8 = 1'b0; ack16 = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; ce = 1'b1; wr = 1'b0; rd = 1'b0; cs8 = 1'b0; cs16 = 1'b0;
        ack8 = 1'b0; ack16 = 1'b0; addr = 2'd0; din = 8'h00; intp8 = '0; intp16 = '0;
        tick(); tick();
        check("rst_req8", 16'(req8), 16'h0);
        check("rst_vec8", 16'(vec8), 16'h0);
        check("rst_dout8", 16'(dout8), 16'h0);
        check("rst_req16", 16'(req16), 16'h0);
        reset_n = 1'b1;
        tick();

        // Edge mode, single, IW4 without auto-EOI.
        bus_wr(0, 0, 8'h13); bus_wr(0, 1, 8'h20); bus_wr(0, 1, 8'h01);
        pulse(0, 3);
        check("lat_req_early", 16'(req8), 16'h0);
        tick();
        check("lat_req", 16'(req8), 16'h1);
        check("vec_l3", 16'(vec8), 16'h23);
        ack(0);
        check("ack_drop", 16'(req8), 16'h0);
        bus_wr(0, 0, 8'h01);
        bus_rd(0, 0, rdata);
        check("isr_l3", 16'(rdata), 16'h08);

        // Nesting: lower priority blocked, higher priority interrupts.
        pulse(0, 5); tick(); tick();
        check("nest_block", 16'(req8), 16'h0);
        pulse(0, 1); tick();
        check("nest_req", 16'(req8), 16'h1);
        check("nest_vec", 16'(vec8), 16'h21);
        ack(0);
        bus_wr(0, 3, 8'h80);
        bus_rd(0, 0, rdata);
        check("nseoi_isr", 16'(rdata), 16'h08);
        check("still_block", 16'(req8), 16'h0);
        bus_wr(0, 3, 8'h03);
        tick();
        check("seoi_vec", 16'(vec8), 16'h25);
        ack(0);
        bus_wr(0, 3, 8'h80);

        // Rotation: level 2 becomes lowest, so 3 now outranks 0.
        bus_wr(0, 3, 8'h42);
        intp8 = 8'h09; tick(); intp8 = 8'h00; tick();
        check("rot_vec", 16'(vec8), 16'h23);
        ack(0); tick(); tick();
        check("rot_block", 16'(req8), 16'h0);
        bus_wr(0, 3, 8'h80);
        tick();
        check("rot_next", 16'(vec8), 16'h20);
        ack(0);
        bus_wr(0, 3, 8'h80);

        // 16-input instance: high mask byte and high-byte readback.
        bus_wr(1, 0, 8'h13); bus_wr(1, 1, 8'h40); bus_wr(1, 1, 8'h01);
        bus_wr(1, 1, 8'hFF); bus_wr(1, 2, 8'hEF);
        pulse(1, 7); tick(); tick();
        check("mask_l7", 16'(req16), 16'h0);
        pulse(1, 12); tick();
        check("vec16_l12", 16'(vec16), 16'h4C);
        bus_rd(1, 0, rdata);
        check("irr16_lo", 16'(rdata), 16'h80);
        bus_rd(1, 2, rdata);
        check("irr16_hi", 16'(rdata), 16'h10);
        bus_wr(1, 0, 8'h02);
        bus_rd(1, 2, rdata);
        check("imr16_hi", 16'(rdata), 16'hEF);
        bus_rd(1, 0, rdata);
        check("imr16_lo", 16'(rdata), 16'hFF);
        ack(1);
        bus_wr(1, 0, 8'h03);
        bus_rd(1, 0, rdata);
        check("top16", 16'(rdata), 16'h0C);

        // Level-triggered with auto-EOI.
        bus_wr(0, 0, 8'h1B); bus_wr(0, 1, 8'h20); bus_wr(0, 1, 8'h02);
        bus_wr(0, 0, 8'h03);
        bus_rd(0, 0, rdata);
        check("top_none", 16'(rdata), 16'hFF);
        intp8[4] = 1'b1; tick(); tick();
        check("lvl_vec", 16'(vec8), 16'h24);
        ack(0);
        check("lvl_ack", 16'(req8), 16'h0);
        tick();
        check("lvl_rereq", 16'(req8), 16'h1);
        check("lvl_revec", 16'(vec8), 16'h24);
        bus_wr(0, 0, 8'h01);
        bus_rd(0, 0, rdata);
        check("aeoi_isr", 16'(rdata), 16'h00);
        intp8[4] = 1'b0;
        ack(0); tick(); tick();
        check("lvl_drop", 16'(req8), 16'h0);
        bus_wr(0, 0, 8'h00);
        bus_rd(0, 0, rdata);
        check("lvl_irr", 16'(rdata), 16'h00);

        // Clock enable low: a pulse that starts and ends while ce=0 is never seen.
        bus_wr(0, 0, 8'h13); bus_wr(0, 1, 8'h20); bus_wr(0, 1, 8'h01);
        ce = 1'b0; intp8[6] = 1'b1; tick(); intp8[6] = 1'b0; ce = 1'b1; tick(); tick();
        check("ce_gate", 16'(req8), 16'h0);

        // Asynchronous reset mid-request.
        pulse(0, 6); tick();
        check("pre_rst_vec", 16'(vec8), 16'h26);
        #2 reset_n = 1'b0;
        #1;
        check("arst_req", 16'(req8), 16'h0);
        check("arst_vec", 16'(vec8), 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        pulse(0, 6); tick(); tick();
        check("uninit_req", 16'(req8), 16'h0);
        bus_rd(0, 0, rdata);
        check("uninit_irr", 16'(rdata), 16'h00);
        bus_wr(0, 0, 8'h13); bus_wr(0, 1, 8'h20); bus_wr(0, 1, 8'h01);
        pulse(0, 6); tick();
        check("reinit_vec", 16'(vec8), 16'h26);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
